// File: rtl/mdu_seq_if.sv
// Operand/result handshake between execute and the multiply/divide sequencer.
// master = execute side, slave = sequencer side.
interface mdu_seq_if #(parameter int XLEN = 64);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/mdu_seq.sv
// Iterative RV64M multiply/divide sequencer: radix-2 shift-add multiplier and
// restoring divider sharing one 128-bit accumulator, driven by an
// IDLE/CALC/FIX/DONE state machine. Operands are converted to magnitudes on
// acceptance and the sign is reapplied in FIX.
module mdu_seq #(
  parameter int XLEN = 64
) (
  input  logic   clk,
  input  logic   resetn,
  input  logic   flush,
  mdu_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  typedef enum logic [1:0] {SEL_LO, SEL_HI, SEL_QUO, SEL_REM} sel_t;

  state_t            state_reg;
  logic [6:0]        cnt_reg;
  logic [2*XLEN-1:0] acc_reg;    // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [XLEN-1:0]   opnd_reg;   // multiplicand or divisor magnitude
  logic              is_mul_reg;
  logic              is_w_reg;
  logic              neg_reg;    // final result needs negation
  sel_t              sel_reg;
  logic              out_valid_reg;
  logic [XLEN-1:0]   result_reg;

  assign bus.in_ready  = (state_reg == IDLE) && !flush;
  assign bus.busy      = (state_reg != IDLE);
  assign bus.out_valid = out_valid_reg;
  assign bus.result    = result_reg;

  // Opcode decode; codes 13-15 fall through to plain MUL.
  logic dec_mul, dec_w, dec_sa, dec_sb;
  sel_t dec_sel;
  always_comb begin
    dec_mul = 1'b1;
    dec_w   = 1'b0;
    dec_sa  = 1'b0;
    dec_sb  = 1'b0;
    dec_sel = SEL_LO;
    case (bus.op)
      4'd1:  begin dec_sel = SEL_HI; dec_sa = 1'b1; dec_sb = 1'b1; end
      4'd2:  begin dec_sel = SEL_HI; dec_sa = 1'b1; end
      4'd3:  begin dec_sel = SEL_HI; end
      4'd4:  begin dec_w = 1'b1; end
      4'd5:  begin dec_mul = 1'b0; dec_sel = SEL_QUO; dec_sa = 1'b1; dec_sb = 1'b1; end
      4'd6:  begin dec_mul = 1'b0; dec_sel = SEL_QUO; end
      4'd7:  begin dec_mul = 1'b0; dec_sel = SEL_REM; dec_sa = 1'b1; dec_sb = 1'b1; end
      4'd8:  begin dec_mul = 1'b0; dec_sel = SEL_REM; end
      4'd9:  begin dec_mul = 1'b0; dec_w = 1'b1; dec_sel = SEL_QUO; dec_sa = 1'b1; dec_sb = 1'b1; end
      4'd10: begin dec_mul = 1'b0; dec_w = 1'b1; dec_sel = SEL_QUO; end
      4'd11: begin dec_mul = 1'b0; dec_w = 1'b1; dec_sel = SEL_REM; dec_sa = 1'b1; dec_sb = 1'b1; end
      4'd12: begin dec_mul = 1'b0; dec_w = 1'b1; dec_sel = SEL_REM; end
      default: ;
    endcase
  end

  // Operand preparation: W truncation/extension, magnitudes, divide special cases.
  logic [XLEN-1:0] ext_a, ext_b, mag_a, mag_b, sext_a32, sp_quo, sp_rem, sp_result;
  logic            neg_a, neg_b, div_zero, div_ovf;
  always_comb begin
    sext_a32 = {{32{bus.a[31]}}, bus.a[31:0]};
    if (dec_w) begin
      ext_a = dec_sa ? sext_a32 : {32'b0, bus.a[31:0]};
      ext_b = dec_sb ? {{32{bus.b[31]}}, bus.b[31:0]} : {32'b0, bus.b[31:0]};
    end else begin
      ext_a = bus.a;
      ext_b = bus.b;
    end
    neg_a = dec_sa && ext_a[XLEN-1];
    neg_b = dec_sb && ext_b[XLEN-1];
    mag_a = neg_a ? -ext_a : ext_a;
    mag_b = neg_b ? -ext_b : ext_b;
    div_zero = !dec_mul && (ext_b == '0);
    div_ovf  = !dec_mul && dec_sa &&
               (dec_w ? ((bus.a[31:0] == 32'h8000_0000) && (bus.b[31:0] == 32'hFFFF_FFFF))
                      : ((bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b == '1)));
    // ext_a already carries the W sign extension for the signed overflow case.
    sp_quo    = div_zero ? '1 : ext_a;
    sp_rem    = div_zero ? (dec_w ? sext_a32 : bus.a) : '0;
    sp_result = (dec_sel == SEL_QUO) ? sp_quo : sp_rem;
  end

  // One iteration of shift-add multiply or restoring divide.
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] acc_step;
  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + {1'b0, (acc_reg[0] ? opnd_reg : '0)};
    div_shift = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_reg};
    if (is_mul_reg)
      acc_step = {mul_sum, acc_reg[XLEN-1:1]};
    else if (!div_diff[XLEN])
      acc_step = {div_diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
    else
      acc_step = {div_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};
  end

  // Sign correction and field selection; W products sit 32 bits higher in acc.
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, field, fix_result;
  always_comb begin
    prod   = is_w_reg ? {32'b0, acc_reg[2*XLEN-1:32]} : acc_reg;
    prod_s = neg_reg ? -prod : prod;
    quo_s  = neg_reg ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
    rem_s  = neg_reg ? -acc_reg[2*XLEN-1:XLEN] : acc_reg[2*XLEN-1:XLEN];
    case (sel_reg)
      SEL_HI:  field = prod_s[2*XLEN-1:XLEN];
      SEL_QUO: field = quo_s;
      SEL_REM: field = rem_s;
      default: field = prod_s[XLEN-1:0];
    endcase
    fix_result = is_w_reg ? {{32{field[31]}}, field[31:0]} : field;
  end

  // Sequencer FSM with registered result and out_valid.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      opnd_reg      <= '0;
      is_mul_reg    <= 1'b0;
      is_w_reg      <= 1'b0;
      neg_reg       <= 1'b0;
      sel_reg       <= SEL_LO;
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
    end else if (flush) begin
      state_reg     <= IDLE;
      out_valid_reg <= 1'b0;
      cnt_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            is_mul_reg <= dec_mul;
            is_w_reg   <= dec_w;
            sel_reg    <= dec_sel;
            neg_reg    <= (dec_sel == SEL_REM) ? neg_a : (neg_a ^ neg_b);
            opnd_reg   <= dec_mul ? mag_a : mag_b;
            // W dividends are pre-shifted so the MSB-first loop starts at bit 31.
            acc_reg    <= dec_mul ? {{XLEN{1'b0}}, mag_b}
                                  : {{XLEN{1'b0}}, (dec_w ? {mag_a[31:0], 32'b0} : mag_a)};
            if (div_zero || div_ovf) begin
              result_reg    <= sp_result;
              out_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end else begin
              cnt_reg   <= dec_w ? 7'd32 : 7'd64;
              state_reg <= CALC;
            end
          end
        end
        CALC: begin
          acc_reg <= acc_step;
          cnt_reg <= cnt_reg - 7'd1;
          if (cnt_reg == 7'd1)
            state_reg <= FIX;
        end
        FIX: begin
          result_reg    <= fix_result;
          out_valid_reg <= 1'b1;
          state_reg     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: a vector table of ops with hand-computed results
// and latencies, plus backpressure, flush and mid-op reset sequences.
module tb_mdu_seq;

  logic clk;
  logic resetn;
  logic flush;
  int   errors = 0;
  int   checks = 0;

  mdu_seq_if #(.XLEN(64)) bus ();

  mdu_seq #(.XLEN(64)) dut (
    .clk    (clk),
    .resetn (resetn),
    .flush  (flush),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // lat = rising edges after the accepting edge until out_valid is seen;
  // 0 means the accepting edge itself loaded the result (divide special cases).
  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // Issue one op from a negedge, measure latency, check result, then consume it.
  task automatic do_op(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y,
                       input logic [63:0] exp, input int exp_lat, input bit consume);
    int guard;
    int lat;
    bit stall_bad;
    guard = 0;
    while (!bus.in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready_before_issue", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.op = o;
    bus.a = x;
    bus.b = y;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    stall_bad = 1'b0;
    while (!bus.out_valid && lat < 200) begin
      if (!bus.busy || bus.in_ready) stall_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    $display("op=%0d a=%h b=%h result=%h lat=%0d", o, x, y, bus.result, lat);
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("result", bus.result, exp);
    chk("busy_stall", 64'(stall_bad || !bus.busy), 64'd0);
    if (consume) begin
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("consume_out_valid", 64'(bus.out_valid), 64'd0);
      chk("consume_in_ready", 64'(bus.in_ready), 64'd1);
    end
  endtask

  initial begin
    bit seen_bad;

    vecs[0]  = '{4'd0,  64'd7,                   64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65};
    vecs[1]  = '{4'd3,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    vecs[2]  = '{4'd1,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                   65};
    vecs[3]  = '{4'd2,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2,                   64'hFFFF_FFFF_FFFF_FFFF, 65};
    vecs[4]  = '{4'd5,  64'd100,                 64'd0,                   64'hFFFF_FFFF_FFFF_FFFF, 0};
    vecs[5]  = '{4'd7,  64'd100,                 64'd0,                   64'd100,                 0};
    vecs[6]  = '{4'd5,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 0};
    vecs[7]  = '{4'd7,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                   0};
    vecs[8]  = '{4'd9,  64'h0000_0000_FFFF_FFF9, 64'd2,                   64'hFFFF_FFFF_FFFF_FFFD, 33};
    vecs[9]  = '{4'd11, 64'h0000_0000_FFFF_FFF9, 64'd2,                   64'hFFFF_FFFF_FFFF_FFFF, 33};
    vecs[10] = '{4'd10, 64'h0000_0000_FFFF_FFFF, 64'd1,                   64'hFFFF_FFFF_FFFF_FFFF, 33};
    vecs[11] = '{4'd4,  64'h0000_0000_7FFF_FFFF, 64'd2,                   64'hFFFF_FFFF_FFFF_FFFE, 33};
    vecs[12] = '{4'd5,  64'hFFFF_FFFF_FFFF_FF9C, 64'd7,                   64'hFFFF_FFFF_FFFF_FFF2, 65};
    vecs[13] = '{4'd7,  64'hFFFF_FFFF_FFFF_FF9C, 64'd7,                   64'hFFFF_FFFF_FFFF_FFFE, 65};
    vecs[14] = '{4'd9,  64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 0};
    vecs[15] = '{4'd12, 64'h0000_0000_8000_0005, 64'd0,                   64'hFFFF_FFFF_8000_0005, 0};
    vecs[16] = '{4'd1,  64'h4000_0000_0000_0000, 64'd4,                   64'd1,                   65};
    vecs[17] = '{4'd15, 64'd6,                   64'd7,                   64'd42,                  65};
    vecs[18] = '{4'd8,  64'd9,                   64'd2,                   64'd1,                   65};
    vecs[19] = '{4'd6,  64'hFFFF_FFFF_FFFF_FFFF, 64'h10,                  64'h0FFF_FFFF_FFFF_FFFF, 65};
    vecs[20] = '{4'd4,  64'h1234_5678_0000_0003, 64'hABCD_0000_0000_0005, 64'd15,                  33};

    resetn = 1'b0;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.op = 4'd0;
    bus.a = '0;
    bus.b = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_result", bus.result, 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 64'(bus.in_ready), 64'd1);

    for (int i = 0; i < NVEC; i++)
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 1'b1);

    // Backpressure: DIVU 9/2 held for 10 cycles before being consumed.
    do_op(4'd6, 64'd9, 64'd2, 64'd4, 65, 1'b0);
    seen_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bus.out_valid || bus.result !== 64'd4 || bus.in_ready) seen_bad = 1'b1;
    end
    chk("backpressure_hold", 64'(seen_bad), 64'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    $display("backpressure release: out_valid=%0d in_ready=%0d", bus.out_valid, bus.in_ready);
    chk("release_out_valid", 64'(bus.out_valid), 64'd0);
    chk("release_in_ready", 64'(bus.in_ready), 64'd1);

    // Flush 20 cycles into a MUL while another op is offered on the flush cycle.
    bus.in_valid = 1'b1;
    bus.op = 4'd0;
    bus.a = 64'd5;
    bus.b = 64'd5;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (20) @(negedge clk);
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.a = 64'd3;
    bus.b = 64'd3;
    chk("flush_cycle_in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    $display("flush: busy=%0d out_valid=%0d result=%h", bus.busy, bus.out_valid, bus.result);
    chk("flush_busy", 64'(bus.busy), 64'd0);
    chk("flush_result_kept", bus.result, 64'd4);
    seen_bad = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (bus.out_valid || bus.busy) seen_bad = 1'b1;
      @(negedge clk);
    end
    chk("flush_no_completion", 64'(seen_bad), 64'd0);
    do_op(4'd0, 64'd3, 64'd3, 64'd9, 65, 1'b1);

    // Asynchronous reset in the middle of an op discards it.
    bus.in_valid = 1'b1;
    bus.op = 4'd6;
    bus.a = 64'd50;
    bus.b = 64'd5;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    #1;
    $display("mid-op reset: busy=%0d out_valid=%0d result=%h", bus.busy, bus.out_valid, bus.result);
    chk("async_reset_busy", 64'(bus.busy), 64'd0);
    chk("async_reset_result", bus.result, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    do_op(4'd6, 64'd50, 64'd5, 64'd10, 65, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
